// File: rtl/mul256_pkg.sv
// Shared types and widths for the 256x256 multiplier scheduler.
package mul256_pkg;

    localparam int unsigned MUL_W     = 256;
    localparam int unsigned PROD_W    = 512;
    localparam int unsigned SEP_WIDTH = 27;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARM,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mul256_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer, wrapping at NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant_c,
    output logic [IDW-1:0]  grant_id_c,
    output logic            found_c
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        found_c    = 1'b0;
        idx        = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = IDW'((32'(ptr) + i) % NREQ);
            if (!found_c && req[idx]) begin
                found_c      = 1'b1;
                grant_c[idx] = 1'b1;
                grant_id_c   = idx;
            end
        end
    end

endmodule

// File: rtl/mul256_sched.sv
// Round-robin scheduler sharing one 256x256 multiplier core among NREQ requesters,
// with a watchdog that aborts an operation when the core never reports done.
module mul256_sched
    import mul256_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*MUL_W-1:0]   req_datax,
    input  logic [NREQ*MUL_W-1:0]   req_datay,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [PROD_W-1:0]       rsp_result,
    output logic                    rsp_err,
    output logic                    core_update,
    output logic [MUL_W-1:0]        core_datax,
    output logic [MUL_W-1:0]        core_datay,
    input  logic                    core_done,
    input  logic [PROD_W-1:0]       core_result,
    output logic                    busy
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [WD_W-1:0] wd;

    logic [NREQ-1:0] grant_c;
    logic [IDW-1:0]  grant_id_c;
    logic            found_c;
    logic            accept_c;
    logic            done_cap_c;
    logic            abort_c;
    logic            rsp_fire_c;
    logic            wd_expired_c;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .grant_c    (grant_c),
        .grant_id_c (grant_id_c),
        .found_c    (found_c)
    );

    assign wd_expired_c = (wd == WD_W'(TIMEOUT));

    // Next state, the combinational grant, and datapath strobes.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept_c   = 1'b0;
        done_cap_c = 1'b0;
        abort_c    = 1'b0;
        rsp_fire_c = 1'b0;
        case (state)
            IDLE: begin
                if (found_c && !rst) begin
                    req_ready  = grant_c;
                    accept_c   = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = ARM;
            ARM: begin
                // A high done here is left over from the previous operation.
                if (wd_expired_c) begin
                    abort_c    = 1'b1;
                    state_next = RESP;
                end else if (!core_done) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (core_done) begin
                    done_cap_c = 1'b1;
                    state_next = RESP;
                end else if (wd_expired_c) begin
                    abort_c    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_fire_c = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            wd          <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_err     <= 1'b0;
            core_update <= 1'b0;
            core_datax  <= '0;
            core_datay  <= '0;
            busy        <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            if (accept_c) begin
                core_datax <= req_datax[32'(grant_id_c) * MUL_W +: MUL_W];
                core_datay <= req_datay[32'(grant_id_c) * MUL_W +: MUL_W];
                rsp_id     <= grant_id_c;
            end
            // Update rises one cycle after the operands settle on the core inputs.
            if (state == LAUNCH) begin
                core_update <= 1'b1;
                wd          <= '0;
            end
            if ((state == ARM || state == WAIT) && !wd_expired_c) begin
                wd <= wd + WD_W'(1);
            end
            if (done_cap_c) begin
                rsp_result <= core_result;
                rsp_err    <= 1'b0;
                rsp_valid  <= 1'b1;
            end
            if (abort_c) begin
                rsp_result <= '0;
                rsp_err    <= 1'b1;
                rsp_valid  <= 1'b1;
            end
            if (rsp_fire_c) begin
                rsp_valid   <= 1'b0;
                core_update <= 1'b0;
                rr_ptr      <= IDW'((32'(rsp_id) + 32'd1) % NREQ);
            end
        end
    end

endmodule
